// File: rtl/vector_pkg.sv
// Shared types and constants for the vector element sequencer.
package vector_pkg;

  localparam int unsigned VLENB    = 4;
  localparam int unsigned NumLanes = 4;

  typedef enum logic [1:0] {
    Sew8    = 2'd0,
    Sew16   = 2'd1,
    Sew32   = 2'd2,
    SewRsvd = 2'd3
  } sew_e;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Elements held by one register at the given SEW; zero for the reserved code.
  function automatic logic [6:0] elems_per_reg(int unsigned vlenb, sew_e sew);
    if (sew == SewRsvd) begin
      return 7'd0;
    end
    return 7'(vlenb >> sew);
  endfunction

endpackage

// File: rtl/vector_byte_mask.sv
// Byte-lane enable for one register-sized op, given the elements still to process.
module vector_byte_mask
  import vector_pkg::*;
(
  input  logic [6:0] remaining,
  input  sew_e       vsew,
  output logic [3:0] byte_en
);

  // Lane b belongs to element (b >> sew); it is live while that element is still pending.
  always_comb begin
    byte_en = '0;
    for (int b = 0; b < NumLanes; b++) begin
      byte_en[b] = (7'(b) >> vsew) < remaining;
    end
  end

endmodule

// File: rtl/vector_element_sequencer.sv
// Splits a vector instruction into per-register ops across the LMUL register group.
module vector_element_sequencer #(
  parameter int unsigned VLENB = vector_pkg::VLENB
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] vl_in,
  input  logic [1:0] vsew_in,
  input  logic [1:0] vlmul_in,
  input  logic       op_ready,
  input  logic       abort,
  output logic       busy,
  output logic       op_valid,
  output logic [2:0] reg_offset,
  output logic [3:0] byte_en,
  output logic       op_first,
  output logic       op_last,
  output logic       done,
  output logic       illegal
);

  import vector_pkg::*;

  state_e     state_q, state_d;
  logic [2:0] offset_q, offset_d;
  logic [5:0] vl_q;
  sew_e       vsew_q;
  logic [1:0] vlmul_q;

  logic       start_accept;
  logic [6:0] per_reg;
  logic [6:0] max_vl;
  logic [6:0] vl_ext;
  logic [6:0] eff_vl;
  logic [6:0] remaining;
  logic       last_op;
  logic [3:0] mask;

  assign start_accept = (state_q == StIdle) && start && !abort;

  // Sequencing arithmetic works only from latched fields.
  assign per_reg   = elems_per_reg(VLENB, vsew_q);
  assign max_vl    = per_reg << vlmul_q;
  assign vl_ext    = {1'b0, vl_q};
  assign eff_vl    = (vl_ext < max_vl) ? vl_ext : max_vl;
  assign remaining = eff_vl - (7'(offset_q) * per_reg);
  assign last_op   = remaining <= per_reg;

  vector_byte_mask u_byte_mask (
    .remaining (remaining),
    .vsew      (vsew_q),
    .byte_en   (mask)
  );

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    unique case (state_q)
      StIdle: begin
        if (start_accept) begin
          offset_d = 3'd0;
          if ((vl_in == 6'd0) || (vsew_in == 2'(SewRsvd))) begin
            state_d = StDone;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (abort) begin
          state_d  = StIdle;
          offset_d = 3'd0;
        end else if (op_ready) begin
          if (last_op) begin
            state_d  = StDone;
            offset_d = 3'd0;
          end else begin
            offset_d = offset_q + 3'd1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d  = StIdle;
        offset_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      offset_q <= 3'd0;
      vl_q     <= 6'd0;
      vsew_q   <= Sew8;
      vlmul_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      if (start_accept) begin
        vl_q    <= vl_in;
        vsew_q  <= sew_e'(vsew_in);
        vlmul_q <= vlmul_in;
      end
    end
  end

  assign busy       = state_q != StIdle;
  assign op_valid   = state_q == StRun;
  assign reg_offset = offset_q;
  assign byte_en    = op_valid ? mask : 4'b0000;
  assign op_first   = op_valid && (offset_q == 3'd0);
  assign op_last    = op_valid && last_op;
  assign done       = state_q == StDone;
  assign illegal    = (state_q == StDone) && (vsew_q == SewRsvd);

endmodule

// File: tb/tb_vector_element_sequencer.sv
// Randomized scoreboard bench for vector_element_sequencer against a behavioural model.
module tb_vector_element_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] vl_in;
  logic [1:0] vsew_in;
  logic [1:0] vlmul_in;
  logic       op_ready;
  logic       abort;
  logic       busy;
  logic       op_valid;
  logic [2:0] reg_offset;
  logic [3:0] byte_en;
  logic       op_first;
  logic       op_last;
  logic       done;
  logic       illegal;

  always #5 clk = ~clk;

  vector_element_sequencer #(.VLENB(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .vl_in      (vl_in),
    .vsew_in    (vsew_in),
    .vlmul_in   (vlmul_in),
    .op_ready   (op_ready),
    .abort      (abort),
    .busy       (busy),
    .op_valid   (op_valid),
    .reg_offset (reg_offset),
    .byte_en    (byte_en),
    .op_first   (op_first),
    .op_last    (op_last),
    .done       (done),
    .illegal    (illegal)
  );

  typedef struct packed {
    logic       is_done;
    logic [2:0] off;
    logic [3:0] be;
    logic       first;
    logic       last;
    logic       ill;
  } ev_t;

  ev_t exp_q[$];
  int  n_pass  = 0;
  int  n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference: count whole registers needed, then fill lanes element by element.
  task automatic model_push(input int vl, input int sew, input int lmul);
    int per, esize, max_vl, eff, n, rem, elems;
    ev_t ev;
    if (vl == 0 || sew == 3) begin
      ev = '0;
      ev.is_done = 1'b1;
      ev.ill = (sew == 3);
      exp_q.push_back(ev);
      return;
    end
    esize  = 1 << sew;
    per    = 4 / esize;
    max_vl = per * (1 << lmul);
    eff    = (vl < max_vl) ? vl : max_vl;
    n      = (eff + per - 1) / per;
    for (int i = 0; i < n; i++) begin
      rem   = eff - i * per;
      elems = (rem < per) ? rem : per;
      ev = '0;
      ev.off   = 3'(i);
      ev.be    = 4'((1 << (elems * esize)) - 1);
      ev.first = (i == 0);
      ev.last  = (i == n - 1);
      exp_q.push_back(ev);
    end
    ev = '0;
    ev.is_done = 1'b1;
    exp_q.push_back(ev);
  endtask

  // Monitor: pops the scoreboard on every handshake and every done pulse.
  logic       prev_stall, prev_hs, prev_last, prev_start;
  logic [7:0] prev_fields;
  initial begin
    prev_stall = 0; prev_hs = 0; prev_last = 0; prev_start = 0; prev_fields = '0;
  end

  always @(negedge clk) begin
    ev_t ev, got;
    logic hs;
    if (reset) begin
      prev_stall = 0; prev_hs = 0; prev_last = 0; prev_start = 0;
    end else begin
      hs = op_valid && op_ready && !abort;
      if (prev_stall) begin
        check("stall_valid_held", op_valid, 1);
        check("stall_fields_stable", {reg_offset, byte_en, op_first}, prev_fields);
      end
      if (prev_hs && !prev_last) check("no_bubble", op_valid, 1);
      if (hs || done) begin
        check("event_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          ev  = exp_q.pop_front();
          got = '0;
          got.is_done = done;
          if (done) begin
            got.ill = illegal;
            check("done_timing", prev_hs_last_or_start(), 1);
          end else begin
            got.off = reg_offset; got.be = byte_en;
            got.first = op_first; got.last = op_last;
          end
          check("event", got, ev);
        end
      end
      prev_stall  = op_valid && !op_ready && !abort;
      prev_fields = {reg_offset, byte_en, op_first};
      prev_last   = op_last;
      prev_hs     = hs;
      prev_start  = start && !busy && !abort;
    end
  end

  function automatic logic prev_hs_last_or_start();
    return (prev_hs && prev_last) || prev_start;
  endfunction

  task automatic check_quiet(input string name);
    check(name, {busy, op_valid, op_first, op_last, done, illegal, byte_en, reg_offset}, 0);
  endtask

  // mode 0: always ready, 1: random ready, 2: hold ready low 3 cycles on op 1
  task automatic run_seq(input int vl, input int sew, input int lmul, input int mode);
    int cyc = 0;
    int stall_cnt = 0;
    model_push(vl, sew, lmul);
    @(posedge clk); #1;
    start = 1; vl_in = 6'(vl); vsew_in = 2'(sew); vlmul_in = 2'(lmul); op_ready = 1;
    do begin
      @(posedge clk); #1;
      cyc++;
      start    = busy ? ($urandom_range(3) == 0) : 1'b0;
      vl_in    = 6'($urandom_range(32));
      vsew_in  = 2'($urandom);
      vlmul_in = 2'($urandom);
      case (mode)
        0: op_ready = 1;
        1: op_ready = ($urandom_range(2) != 0);
        default: begin
          if (op_valid && reg_offset == 3'd1 && stall_cnt < 3) begin
            op_ready = 0;
            stall_cnt++;
          end else begin
            op_ready = 1;
          end
        end
      endcase
    end while (busy && cyc < 200);
    start = 0;
    check("seq_finished", busy, 0);
    if (busy) begin
      reset = 1; @(posedge clk); #1; reset = 0;
    end
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_offset(input int off);
    int cyc = 0;
    while (!(op_valid && reg_offset == 3'(off)) && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("reached_offset", {op_valid, reg_offset}, {1'b1, 3'(off)});
  endtask

  initial begin
    reset = 1; start = 0; vl_in = 0; vsew_in = 0; vlmul_in = 0; op_ready = 0; abort = 0;
    repeat (2) @(posedge clk);
    #1;
    start = 1; vl_in = 6'd8;
    check_quiet("in_reset");
    @(posedge clk); #1;
    reset = 0; start = 0;
    @(posedge clk); #1;
    check_quiet("after_reset");

    run_seq(7, 0, 1, 0);
    run_seq(32, 0, 0, 0);
    run_seq(5, 1, 2, 2);
    run_seq(0, 0, 2, 0);
    run_seq(9, 3, 1, 0);
    run_seq(0, 3, 0, 0);

    // Abort at offset 3; handshake offered in the same cycle must lose.
    model_push(8, 2, 3);
    @(posedge clk); #1;
    start = 1; vl_in = 6'd8; vsew_in = 2'd2; vlmul_in = 2'd3; op_ready = 1;
    @(posedge clk); #1;
    start = 0;
    wait_offset(3);
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    check_quiet("after_abort");
    exp_q.delete();
    @(posedge clk); #1;
    check("no_done_after_abort", done, 0);

    // Abort in IDLE blocks a simultaneous start.
    start = 1; abort = 1; vl_in = 6'd4;
    @(posedge clk); #1;
    start = 0; abort = 0;
    check("abort_blocks_start", busy, 0);
    run_seq(8, 2, 3, 1);

    // Reset mid-run at offset 2 with a start attempt during reset.
    model_push(8, 2, 3);
    @(posedge clk); #1;
    start = 1; vl_in = 6'd8; vsew_in = 2'd2; vlmul_in = 2'd3; op_ready = 1;
    @(posedge clk); #1;
    start = 0;
    wait_offset(2);
    reset = 1; start = 1; op_ready = 0;
    @(posedge clk); #1;
    check_quiet("reset_mid_run");
    reset = 0; start = 0;
    exp_q.delete();
    @(posedge clk); #1;
    check_quiet("idle_after_reset");

    for (int i = 0; i < 40; i++) begin
      run_seq($urandom_range(32), ($urandom_range(7) == 0) ? 3 : $urandom_range(2),
              $urandom_range(3), $urandom_range(2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
